// File: rtl/adder_pkg.sv
// Shared defaults and segment sizing for the pipelined carry-chain adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bits of the carry chain resolved by each pipeline stage.
  function automatic int seg_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One combinational slice of the carry chain: SEG-bit add with carry-in and carry-out.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic [SEG-1:0] sum,
  output logic           carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, carry_in};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chain adder split into STAGES registered segments with a stall-able valid/ready pipeline.
// Optional signed-overflow output is enabled by defining PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || WIDTH < STAGES || WIDTH % STAGES != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  // Handshake: input transfers on i_valid & o_ready, output on o_valid & i_ready.
  // The whole pipeline moves as one (advance) or holds as one; no per-stage bubbles collapse.
  logic advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;
    localparam int DONE = LO + SEG;

    logic [SEG-1:0]  seg_a;
    logic [SEG-1:0]  seg_b;
    logic [SEG-1:0]  seg_sum;
    logic            seg_cin;
    logic            seg_cout;
    logic            valid_in;
    logic [DONE-1:0] sum_next;
    logic [DONE-1:0] sum_q;
    logic            carry_q;
    logic            valid_q;

    if (k == 0) begin : g_head
      assign seg_a    = i_a[SEG-1:0];
      assign seg_b    = i_b[SEG-1:0];
      assign seg_cin  = i_carry;
      assign valid_in = i_valid;
      assign sum_next = seg_sum;
    end else begin : g_body
      // Low bits of the previous stage's remaining operands are this stage's segment.
      assign seg_a    = g_stage[k-1].g_rem.rem_a_q[SEG-1:0];
      assign seg_b    = g_stage[k-1].g_rem.rem_b_q[SEG-1:0];
      assign seg_cin  = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sum_next = {seg_sum, g_stage[k-1].sum_q};
    end

    adder_segment #(.SEG(SEG)) u_segment (
      .a         (seg_a),
      .b         (seg_b),
      .carry_in  (seg_cin),
      .sum       (seg_sum),
      .carry_out (seg_cout)
    );

    // Operand bits not yet consumed travel with the item (input skew).
    if (k < LAST) begin : g_rem
      logic [WIDTH-DONE-1:0] rem_a_in;
      logic [WIDTH-DONE-1:0] rem_b_in;
      logic [WIDTH-DONE-1:0] rem_a_q;
      logic [WIDTH-DONE-1:0] rem_b_q;

      if (k == 0) begin : g_from_port
        assign rem_a_in = i_a[WIDTH-1:SEG];
        assign rem_b_in = i_b[WIDTH-1:SEG];
      end else begin : g_from_stage
        assign rem_a_in = g_stage[k-1].g_rem.rem_a_q[WIDTH-LO-1:SEG];
        assign rem_b_in = g_stage[k-1].g_rem.rem_b_q[WIDTH-LO-1:SEG];
      end

      always_ff @(posedge i_clk) begin
        if (advance) begin
          rem_a_q <= rem_a_in;
          rem_b_q <= rem_b_in;
        end
      end
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic sign_a_in;
    logic sign_b_in;
    logic sign_a_q;
    logic sign_b_q;

    if (k == 0) begin : g_sign_head
      assign sign_a_in = i_a[WIDTH-1];
      assign sign_b_in = i_b[WIDTH-1];
    end else begin : g_sign_body
      assign sign_a_in = g_stage[k-1].sign_a_q;
      assign sign_b_in = g_stage[k-1].sign_b_q;
    end

    always_ff @(posedge i_clk) begin
      if (advance) begin
        sign_a_q <= sign_a_in;
        sign_b_q <= sign_b_in;
      end
    end
`endif

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        valid_q <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_in;
      end
    end

    // Completed low segments accumulate alongside the item (output de-skew).
    always_ff @(posedge i_clk) begin
      if (advance) begin
        sum_q   <= sum_next;
        carry_q <= seg_cout;
      end
    end
  end

  assign advance = !g_stage[LAST].valid_q || i_ready;
  assign o_ready = advance;
  assign o_valid = g_stage[LAST].valid_q;
  assign o_sum   = g_stage[LAST].sum_q;
  assign o_carry = g_stage[LAST].carry_q;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign o_overflow = (g_stage[LAST].sign_a_q == g_stage[LAST].sign_b_q) &&
                      (g_stage[LAST].sum_q[WIDTH-1] != g_stage[LAST].sign_a_q);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder (8-bit/4-stage plus 32-bit with 1,2,4,8 stages).
module tb_pipelined_adder;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main DUT: WIDTH=8, STAGES=4
  logic       in_valid, dut_ready, out_valid, out_ready;
  logic [7:0] a, b, sum;
  logic       carry_in, carry_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic       overflow;
`endif

  pipelined_adder #(.WIDTH(8), .STAGES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(dut_ready),
    .i_a(a), .i_b(b), .i_carry(carry_in), .o_valid(out_valid), .i_ready(out_ready),
    .o_sum(sum), .o_carry(carry_out)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    , .o_overflow(overflow)
`endif
  );

  // randomised DUTs: WIDTH=32, STAGES = 1,2,4,8
  logic        r_valid[4], r_ready[4], r_o_ready[4], r_o_valid[4], r_cout[4];
  logic [31:0] r_sum[4];
  logic [31:0] r_a, r_b;
  logic        r_cin;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic        r_ov[4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_rand_dut
    pipelined_adder #(.WIDTH(32), .STAGES(1 << g)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(r_valid[g]), .o_ready(r_o_ready[g]),
      .i_a(r_a), .i_b(r_b), .i_carry(r_cin), .o_valid(r_o_valid[g]), .i_ready(r_ready[g]),
      .o_sum(r_sum[g]), .o_carry(r_cout[g])
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      , .o_overflow(r_ov[g])
`endif
    );
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    logic        ov;
    t  = {1'b0, x} + {1'b0, y} + {32'd0, c};
    ov = (x[31] == y[31]) && (t[31] != x[31]);
    return {ov, t};
  endfunction

  task automatic pop_check(input int g);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check("rand_unexpected_output", {63'd0, r_o_valid[g]}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("rand_sum_s%0d", 1 << g), {31'd0, r_cout[g], r_sum[g]}, {31'd0, e[32:0]});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      check($sformatf("rand_ovf_s%0d", 1 << g), {63'd0, r_ov[g]}, {63'd0, e[33]});
`endif
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          output int lat, output logic [7:0] s, output logic c, output logic ov);
    a = ta; b = tb_v; carry_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0; s = 8'h00; c = 1'b0; ov = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (out_valid) begin
        lat = n; s = sum; c = carry_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        ov = overflow;
`endif
        break;
      end
      tick();
    end
    tick();
  endtask

  // back-to-back vectors with hand-computed {carry,sum}
  logic [7:0] vec_a[10] = '{8'h00, 8'h01, 8'h0F, 8'h80, 8'hFF, 8'h55, 8'h55, 8'h3C, 8'h12, 8'h7E};
  logic [7:0] vec_b[10] = '{8'h00, 8'h01, 8'h01, 8'h80, 8'hFF, 8'hAA, 8'hAA, 8'hC3, 8'h34, 8'h03};
  logic       vec_c[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [8:0] vec_s[10] = '{9'h000, 9'h002, 9'h010, 9'h100, 9'h1FF, 9'h0FF, 9'h100, 9'h100, 9'h046, 9'h082};

  initial begin
    int         lat, got, first, last, idx, cnt;
    logic [7:0] s;
    logic       c, ov;
    logic       found;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 8'hAA; b = 8'h55; carry_in = 1'b0;
    r_a = '0; r_b = '0; r_cin = 1'b0;
    for (int g = 0; g < 4; g++) begin
      r_valid[g] = 1'b0; r_ready[g] = 1'b0;
    end

    // reset state; offered input during reset must not be captured
    @(negedge clk);
    tick(); tick();
    #1;
    check("reset_o_valid", {63'd0, out_valid}, 64'd0);
    check("reset_o_ready", {63'd0, dut_ready}, 64'd1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (out_valid) cnt++;
    end
    check("reset_no_capture", 64'(cnt), 64'd0);

    // full ripple, latency 4
    send_one(8'hFF, 8'h01, 1'b0, lat, s, c, ov);
    check("ripple_latency", 64'(lat), 64'd4);
    check("ripple_sum", {56'd0, s}, 64'h00);
    check("ripple_carry", {63'd0, c}, 64'd1);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    check("ripple_ovf", {63'd0, ov}, 64'd0);
    send_one(8'h7F, 8'h01, 1'b0, lat, s, c, ov);
    check("ovf_sum", {56'd0, s}, 64'h80);
    check("ovf_carry", {63'd0, c}, 64'd0);
    check("ovf_flag", {63'd0, ov}, 64'd1);
`endif

    // ten back-to-back items
    got = 0; first = -1; last = -1; idx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 10) begin
        a = vec_a[cyc]; b = vec_b[cyc]; carry_in = vec_c[cyc]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 10) check("b2b_o_ready", {63'd0, dut_ready}, 64'd1);
      if (out_valid) begin
        got++;
        if (first < 0) first = cyc;
        last = cyc;
        if (idx < 10) check($sformatf("b2b_sum_%0d", idx), {55'd0, carry_out, sum}, {55'd0, vec_s[idx]});
        idx++;
      end
      tick();
    end
    check("b2b_count", 64'(got), 64'd10);
    check("b2b_first_cycle", 64'(first), 64'd4);
    check("b2b_span", 64'(last - first), 64'd9);

    // output stall holds result and blocks input
    a = 8'h12; b = 8'h34; carry_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("stall_arrive", {63'd0, found}, 64'd1);
    a = 8'h01; b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      #1;
      check("stall_o_valid", {63'd0, out_valid}, 64'd1);
      check("stall_sum", {55'd0, carry_out, sum}, 64'h047);
      check("stall_o_ready", {63'd0, dut_ready}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_sum", {55'd0, carry_out, sum}, 64'h047);
    check("release_o_ready", {63'd0, dut_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      if (out_valid) begin
        cnt++;
        check("after_stall_sum", {55'd0, carry_out, sum}, 64'h002);
      end
      tick();
    end
    check("after_stall_count", 64'(cnt), 64'd1);

    // reset with three items in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 8'(i + 1); b = 8'h10; carry_in = 1'b0; in_valid = 1'b1;
      tick();
    end
    rst = 1'b1; a = 8'h77;
    tick();
    #1;
    check("flush_o_valid", {63'd0, out_valid}, 64'd0);
    check("flush_o_ready", {63'd0, dut_ready}, 64'd1);
    rst = 1'b0; in_valid = 1'b0;
    cnt = 0;
    repeat (8) begin
      tick();
      if (out_valid) cnt++;
    end
    check("flush_no_stale", 64'(cnt), 64'd0);

    // randomised 32-bit runs, one stage count at a time
    for (int g = 0; g < 4; g++) begin
      exp_q.delete();
      for (int cyc = 0; cyc < 300; cyc++) begin
        r_a = $urandom; r_b = $urandom; r_cin = 1'($urandom_range(0, 1));
        for (int j = 0; j < 4; j++) begin
          r_valid[j] = (j == g) ? 1'($urandom_range(0, 1)) : 1'b0;
          r_ready[j] = ($urandom_range(0, 3) != 0);
        end
        #1;
        if (r_valid[g] && r_o_ready[g]) exp_q.push_back(model(r_a, r_b, r_cin));
        if (r_o_valid[g] && r_ready[g]) pop_check(g);
        tick();
      end
      for (int j = 0; j < 4; j++) begin
        r_valid[j] = 1'b0; r_ready[j] = 1'b1;
      end
      for (int n = 0; n < 20; n++) begin
        #1;
        if (r_o_valid[g]) pop_check(g);
        tick();
      end
      check($sformatf("rand_drain_s%0d", 1 << g), 64'(exp_q.size()), 64'd0);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
